serial_byte_feeder: RTL and testbench
=====================================

# serial_byte_feeder

- Upstream feeder for the team's 8-bit serial-in shift register.
- Accepts parallel bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte MSB-first onto `data`, with one `shift_enable` pulse per bit, so the downstream register holds the byte at bit 7 down to bit 0 after eight pulses.
- Consecutive bytes stream without gaps while the FIFO is non-empty.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `CLKS_PER_BIT`, default 1: clock cycles per serialized bit; at least 1.

Ports:
- `clk` input 1: the single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_data` input 8: byte to enqueue.
- `in_valid` input 1: `in_data` is offered.
- `in_ready` output 1: FIFO can accept a byte this cycle.
- `data` output 1: current serial bit; drives the downstream `data` input.
- `shift_enable` output 1: downstream samples `data` this cycle.
- `byte_done` output 1: one-cycle pulse coincident with the 8th `shift_enable` of a byte.
- `busy` output 1: high in state SHIFT.
- `fifo_count` output clog2(DEPTH)+1: number of bytes currently queued.

## Operation

- **Reset values.** While `reset` is high, all registered state clears:
  - FIFO is emptied;
  - state becomes IDLE;
  - `data`, `shift_enable`, `byte_done`, `busy` and `fifo_count` are all 0.
  - `in_ready` is forced to 0 during reset and rises the cycle after `reset` falls.
- **Enqueue.**
  - `in_ready` = (`fifo_count` < DEPTH) and not reset. It is computed from the count only; a pop in the same cycle does not open space.
  - A byte is written at a clock edge where `in_valid` and `in_ready` are both high.
  - `in_data` is ignored when the handshake does not complete.
- **Bit counting.** A shift buffer holds the current byte, a 3-bit bit index counts 7 down to 0, and a bit timer counts 0 to CLKS_PER_BIT-1.
- **IDLE.**
  - `data`=0, `shift_enable`=0.
  - If `fifo_count`>0: pop the head into the shift buffer, set bit index=7, clear the timer, go to SHIFT.
- **SHIFT.**
  - `data` = shift buffer[bit index], held for the whole bit period.
  - `shift_enable` is high on the cycle where timer = CLKS_PER_BIT-1; with CLKS_PER_BIT=1 it stays high for every bit.
  - On a `shift_enable` cycle with bit index > 0: decrement the index and clear the timer.
  - On a `shift_enable` cycle with bit index = 0:
    - `byte_done`=1;
    - if the FIFO is non-empty, pop the next byte, set index=7 and stay in SHIFT, with no idle cycle between bytes;
    - otherwise go to IDLE.
- **Simultaneous push and pop.** `fifo_count` is unchanged and the FIFO pointers wrap modulo DEPTH.
- **Full FIFO with `in_valid` held.** The byte is not accepted; the source must hold it until `in_ready` rises.
- **Reset mid-byte.** The partial byte is abandoned, no further `shift_enable` is issued, and the downstream register keeps its partial contents (clearing it is the downstream reset's job). Queued bytes are lost.

## Timing

- **Accept to first bit.** A byte accepted at edge N into an empty, idle block is popped at edge N+1. The first bit (bit 7) is on `data` in the cycle after edge N+1, giving latency 1 cycle after acceptance. With CLKS_PER_BIT=1, `shift_enable` is high in that same cycle.
- **Byte period.** 8×CLKS_PER_BIT cycles; continuous while queued bytes remain.
- **`byte_done`.** Asserted in the same cycle as the final `shift_enable`. After that edge the downstream register holds the full byte.
- **Return to idle.** `busy` falls the cycle after the last bit period if the FIFO is empty.
- **Outputs.** `data`, `shift_enable`, `byte_done` and `busy` are driven from registered state only; they have no combinational path from `in_valid` or `in_data`.

## Test plan

- CLKS_PER_BIT=1: push 0xA5 → `data` sequence 1,0,1,0,0,1,0,1 over 8 consecutive `shift_enable` cycles; `byte_done` on the 8th; downstream `stored_data`=0xA5; `busy` falls one cycle later.
- Push 0x3C then 0xC3 back-to-back → 16 consecutive `shift_enable` cycles with no gap; `byte_done` pulses twice, 8 cycles apart; downstream holds 0x3C, then 0xC3.
- DEPTH=4: hold `in_valid` with 0x01..0x06 while serializing → `in_ready` drops when `fifo_count`=4; all six bytes are emitted in order with none lost or duplicated.
- CLKS_PER_BIT=3: push 0x80 → `shift_enable` on every 3rd cycle and `data` stable for 3 cycles per bit; total 24 cycles; first bit is 1, the rest 0.
- Assert `reset` for 1 cycle after 3 bits of 0xFF with 0x55 queued → `shift_enable`, `busy` and `fifo_count` go to 0 at that edge; no further output; a new push of 0x0F afterwards serializes cleanly.
- Push and pop in the same edge with `fifo_count`=2 → count stays 2; order is preserved across pointer wrap after more than DEPTH total bytes.

Source files
------------

// File: rtl/serial_byte_feeder.sv
// serial_byte_feeder: byte FIFO feeding an MSB-first serial stream
// with one shift_enable strobe per bit for an 8-bit shift register.
module serial_byte_feeder #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    data,
  output logic                    shift_enable,
  output logic                    byte_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [0:0]    r_state;
  logic [7:0]    r_shbuf;
  logic [2:0]    r_idx;
  logic [TW-1:0] r_timer;

  logic w_push;
  logic w_pop;
  logic w_tick;
  logic w_last;
  logic w_shift;

  // Space is judged on the registered count only; a same-cycle pop
  // never opens a slot.
  assign in_ready = (r_count < FULL) && !reset;
  assign w_push   = in_valid && in_ready;
  assign w_shift  = (r_state == ST_SHIFT);
  assign w_tick   = w_shift && (r_timer == TLAST);
  assign w_last   = w_tick && (r_idx == 3'd0);
  assign w_pop    = (r_count != '0) && (!w_shift || w_last);

  assign data         = w_shift && r_shbuf[r_idx];
  assign shift_enable = w_tick;
  assign byte_done    = w_last;
  assign busy         = w_shift;
  assign fifo_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A pop on the final bit reloads the buffer so bytes run back to back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shbuf <= '0;
      r_idx   <= '0;
      r_timer <= '0;
    end else if (w_pop) begin
      r_state <= ST_SHIFT;
      r_shbuf <= r_mem[r_rd_ptr];
      r_idx   <= 3'd7;
      r_timer <= '0;
    end else if (w_last) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else if (w_tick) begin
      r_idx   <= r_idx - 3'd1;
      r_timer <= '0;
    end else if (w_shift) begin
      r_timer <= r_timer + TW'(1);
    end
  end

endmodule

// File: tb/tb_serial_byte_feeder.sv
// Bench for serial_byte_feeder: two instances (1 and 3 clocks per bit)
// checked cycle by cycle against a queue-based reference model.
module tb_serial_byte_feeder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst [2];
  logic       vld [2];
  logic [7:0] din [2];
  logic       rdy [2];
  logic       dat [2];
  logic       se  [2];
  logic       bd  [2];
  logic       bsy [2];
  logic [2:0] cnt [2];

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  logic [7:0] acc [2][4096];
  int         wi [2];
  int         ri [2];
  bit         m_busy [2];
  int         m_cyc [2];
  logic [7:0] m_cur [2];
  logic [7:0] sr [2];

  always #5 clk = ~clk;

  serial_byte_feeder #(.DEPTH(DEPTH), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .reset(rst[0]), .in_data(din[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .data(dat[0]), .shift_enable(se[0]),
    .byte_done(bd[0]), .busy(bsy[0]), .fifo_count(cnt[0])
  );

  serial_byte_feeder #(.DEPTH(DEPTH), .CLKS_PER_BIT(3)) u_dut3 (
    .clk(clk), .reset(rst[1]), .in_data(din[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .data(dat[1]), .shift_enable(se[1]),
    .byte_done(bd[1]), .busy(bsy[1]), .fifo_count(cnt[1])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: queue of accepted bytes plus position within the current byte.
  always @(negedge clk) begin
    int cpb, sz;
    bit ese, edat, ebd, hs, pend;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        cpb  = (k == 1) ? 3 : 1;
        sz   = wi[k] - ri[k];
        ese  = m_busy[k] && (m_cyc[k] % cpb == cpb - 1);
        edat = m_busy[k] && m_cur[k][7 - m_cyc[k] / cpb];
        ebd  = m_busy[k] && (m_cyc[k] == 8 * cpb - 1);
        check($sformatf("busy%0d", k), 32'(bsy[k]), 32'(m_busy[k]));
        check($sformatf("shift_en%0d", k), 32'(se[k]), 32'(ese));
        check($sformatf("data%0d", k), 32'(dat[k]), 32'(edat));
        check($sformatf("byte_done%0d", k), 32'(bd[k]), 32'(ebd));
        check($sformatf("count%0d", k), 32'(cnt[k]), 32'(sz));
        check($sformatf("in_ready%0d", k), 32'(rdy[k]),
              32'((sz < DEPTH) && !rst[k]));
        if (se[k]) sr[k] = {sr[k][6:0], dat[k]};
        if (bd[k] && !rst[k])
          check($sformatf("stored%0d", k), 32'(sr[k]), 32'(m_cur[k]));
        hs   = vld[k] && !rst[k] && (sz < DEPTH);
        pend = (sz > 0);
        if (rst[k]) begin
          ri[k]     = wi[k];
          m_busy[k] = 1'b0;
          m_cyc[k]  = 0;
        end else begin
          if (m_busy[k] && m_cyc[k] != 8 * cpb - 1) begin
            m_cyc[k]++;
          end else if (pend) begin
            m_cur[k]  = acc[k][ri[k] % 4096];
            ri[k]++;
            m_busy[k] = 1'b1;
            m_cyc[k]  = 0;
          end else begin
            m_busy[k] = 1'b0;
          end
          if (hs) begin
            acc[k][wi[k] % 4096] = din[k];
            wi[k]++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] b);
    bit ok;
    bit r;
    ok = 1'b0;
    vld[k] = 1'b1;
    din[k] = b;
    for (int n = 0; n < 200; n++) begin
      r = rdy[k];
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("push_timeout", 32'd0, 32'd1);
    vld[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!bsy[k] && cnt[k] == 3'd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; vld[k] = 1'b0; din[k] = 8'h00;
      wi[k] = 0; ri[k] = 0; m_busy[k] = 1'b0; m_cyc[k] = 0;
      m_cur[k] = 8'h00; sr[k] = 8'h00;
    end
    tick();
    started = 1'b1;
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    push(0, 8'hA5);
    wait_idle(0);
    push(0, 8'h3C);
    push(0, 8'hC3);
    wait_idle(0);
    for (int i = 1; i <= 6; i++) push(0, 8'(i));
    wait_idle(0);

    push(0, 8'hFF);
    push(0, 8'h55);
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    tick();
    push(0, 8'h0F);
    wait_idle(0);

    push(1, 8'h80);
    wait_idle(1);
    push(1, 8'h96);
    push(1, 8'h69);
    wait_idle(1);

    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 600; c++) begin
        if (c < 300) vld[k] = ($urandom_range(0, 1) == 0);
        else         vld[k] = ($urandom_range(0, 7) == 0);
        din[k] = 8'($urandom);
        rst[k] = ($urandom_range(0, 99) == 0);
        tick();
      end
      vld[k] = 1'b0;
      rst[k] = 1'b0;
      tick();
      wait_idle(k);
    end

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
